elastic_fifo_counted: RTL and testbench

- Parametrised successor to the dataless elastic FIFO. It carries a data payload, supports any depth (including non-power-of-two), reports occupancy and almost-full status, and accepts a synchronous flush.
- Optional zero-latency bypass when empty.
- Sits between dataflow units as a slack buffer on valid/ready channels. Occupancy and almost-full feed buffer-placement and throttling logic.

---
 rtl/elastic_fifo_counted_if.sv | 28 ++
 rtl/elastic_fifo_counted.sv | 76 +++++++
 tb/tb_elastic_fifo_counted.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/elastic_fifo_counted_if.sv
// elastic_fifo_counted channel bundle.
// Payload handshakes, flush and occupancy status.
interface elastic_fifo_counted_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
);
  localparam int CW = $clog2(NUM_SLOTS + 1);

  logic                  flush;
  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;
  logic [CW-1:0]         count;
  logic                  almost_full;

  modport master (
    output flush, ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid, count, almost_full
  );

  modport slave (
    input  flush, ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid, count, almost_full
  );
endinterface

// File: rtl/elastic_fifo_counted.sv
// Counted elastic FIFO with payload, flush and optional bypass.
// Any depth; pointers wrap by explicit compare.
module elastic_fifo_counted #(
  parameter int DATA_WIDTH         = 32,
  parameter int NUM_SLOTS          = 4,
  parameter int ALMOST_FULL_THRESH = NUM_SLOTS - 1,
  parameter int BYPASS             = 0
) (
  input logic                  clk,
  input logic                  rst,
  elastic_fifo_counted_if.slave bus
);
  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam bit BYP = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nx;
  logic                  full;
  logic                  empty;
  logic                  rd;
  logic                  wr;
  logic                  pass;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(NUM_SLOTS - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (cnt == CW'(NUM_SLOTS));
  assign empty = (cnt == '0);

  assign bus.ins_ready  = ~bus.flush & (~full | bus.outs_ready);
  assign bus.outs_valid = ~bus.flush & (~empty | (BYP & bus.ins_valid));
  assign bus.outs       = (BYP && empty) ? bus.ins : mem[head];
  assign bus.count      = cnt;
  assign bus.almost_full = (cnt >= CW'(ALMOST_FULL_THRESH));

  assign pass = BYP & empty & bus.ins_valid & bus.outs_ready & ~bus.flush;
  assign rd   = bus.outs_valid & bus.outs_ready & ~empty;
  assign wr   = bus.ins_valid & bus.ins_ready & ~pass;

  // Occupancy update from the write/read pair.
  always_comb begin
    cnt_nx = cnt;
    unique case ({wr, rd})
      2'b10:   cnt_nx = cnt + CW'(1);
      2'b01:   cnt_nx = cnt - CW'(1);
      default: cnt_nx = cnt;
    endcase
  end

  // Pointer and count state; flush returns to the empty state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (bus.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (rd) head <= bump(head);
      if (wr) tail <= bump(tail);
      cnt <= cnt_nx;
    end
  end

  // Payload storage, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr) mem[tail] <= bus.ins;
  end
endmodule

// File: tb/tb_elastic_fifo_counted.sv
// Scoreboard bench for elastic_fifo_counted.
// Three instances: depth 4, depth 3, depth 4 with bypass.
module tb_elastic_fifo_counted;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  always #5 clk = ~clk;

  elastic_fifo_counted_if #(.DATA_WIDTH(8), .NUM_SLOTS(4)) f0 ();
  elastic_fifo_counted_if #(.DATA_WIDTH(8), .NUM_SLOTS(3)) f1 ();
  elastic_fifo_counted_if #(.DATA_WIDTH(8), .NUM_SLOTS(4)) f2 ();

  elastic_fifo_counted #(
    .DATA_WIDTH(8), .NUM_SLOTS(4), .BYPASS(0)
  ) u0 (.clk(clk), .rst(rst_n), .bus(f0));

  elastic_fifo_counted #(
    .DATA_WIDTH(8), .NUM_SLOTS(3), .BYPASS(0)
  ) u1 (.clk(clk), .rst(rst_n), .bus(f1));

  elastic_fifo_counted #(
    .DATA_WIDTH(8), .NUM_SLOTS(4), .BYPASS(1)
  ) u2 (.clk(clk), .rst(rst_n), .bus(f2));

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept, pop and compare on output transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (f0.flush) q0.delete();
      else begin
        if (f0.ins_valid && f0.ins_ready) q0.push_back(f0.ins);
        if (f0.outs_valid && f0.outs_ready) begin
          if (q0.size() == 0) check("f0_underflow", 1, 0);
          else check("f0_data", {24'h0, f0.outs}, {24'h0, q0.pop_front()});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (f1.flush) q1.delete();
      else begin
        if (f1.ins_valid && f1.ins_ready) q1.push_back(f1.ins);
        if (f1.outs_valid && f1.outs_ready) begin
          if (q1.size() == 0) check("f1_underflow", 1, 0);
          else check("f1_data", {24'h0, f1.outs}, {24'h0, q1.pop_front()});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (f2.flush) q2.delete();
      else begin
        if (f2.ins_valid && f2.ins_ready) q2.push_back(f2.ins);
        if (f2.outs_valid && f2.outs_ready) begin
          if (q2.size() == 0) check("f2_underflow", 1, 0);
          else check("f2_data", {24'h0, f2.outs}, {24'h0, q2.pop_front()});
        end
      end
    end
  end

  initial begin
    int tok;
    int got;
    int cyc;
    logic acc;

    f0.flush = 0; f0.ins = 0; f0.ins_valid = 0; f0.outs_ready = 0;
    f1.flush = 0; f1.ins = 0; f1.ins_valid = 0; f1.outs_ready = 0;
    f2.flush = 0; f2.ins = 0; f2.ins_valid = 0; f2.outs_ready = 0;

    #3;
    check("rst_count", 32'(f0.count), 0);
    check("rst_ovalid", 32'(f0.outs_valid), 0);
    check("rst_irdy", 32'(f0.ins_ready), 1);
    check("rst_af", 32'(f0.almost_full), 0);
    #9 rst_n = 1'b1;
    drv();

    // Fill depth-4 FIFO with the consumer stalled.
    for (int i = 0; i < 4; i++) begin
      f0.ins = 8'(8'h11 * (i + 1));
      f0.ins_valid = 1;
      @(negedge clk);
      check("fill_irdy", 32'(f0.ins_ready), 1);
      drv();
      f0.ins_valid = 0;
      @(negedge clk);
      check("fill_count", 32'(f0.count), 32'(i + 1));
      check("fill_af", 32'(f0.almost_full), (i + 1 >= 3) ? 1 : 0);
      drv();
    end
    check("full_irdy", 32'(f0.ins_ready), 0);

    // Write and read in the same edge while full.
    f0.ins = 8'h55;
    f0.ins_valid = 1;
    f0.outs_ready = 1;
    @(negedge clk);
    check("fullrw_irdy", 32'(f0.ins_ready), 1);
    check("fullrw_head", 32'(f0.outs), 32'h11);
    drv();
    f0.ins_valid = 0;
    @(negedge clk);
    check("fullrw_count", 32'(f0.count), 4);
    repeat (4) drv();
    @(negedge clk);
    check("drain_count", 32'(f0.count), 0);
    check("drain_ovalid", 32'(f0.outs_valid), 0);
    check("drain_sb", 32'(q0.size()), 0);
    drv();
    f0.outs_ready = 0;

    // Depth-3 stream with a half-rate consumer.
    tok = 1;
    got = 0;
    cyc = 0;
    while (got < 10 && cyc < 100) begin
      f1.ins = 8'(tok);
      f1.ins_valid = (tok <= 10);
      f1.outs_ready = (cyc % 2 == 0);
      @(negedge clk);
      check("wrap_cnt_max", 32'(f1.count <= 3), 1);
      acc = f1.ins_valid && f1.ins_ready;
      if (f1.outs_valid && f1.outs_ready) got++;
      drv();
      if (acc) tok++;
      cyc++;
    end
    f1.ins_valid = 0;
    f1.outs_ready = 0;
    check("wrap_got", 32'(got), 10);
    check("wrap_sb", 32'(q1.size()), 0);

    // Bypass: straight through when empty and ready.
    f2.ins = 8'hA5;
    f2.ins_valid = 1;
    f2.outs_ready = 1;
    @(negedge clk);
    check("byp_ovalid", 32'(f2.outs_valid), 1);
    check("byp_outs", 32'(f2.outs), 32'hA5);
    drv();
    f2.ins = 8'h5A;
    f2.outs_ready = 0;
    @(negedge clk);
    check("byp_pass_cnt", 32'(f2.count), 0);
    check("byp_stall_out", 32'(f2.outs), 32'h5A);
    drv();
    f2.ins_valid = 0;
    f2.ins = 8'h00;
    @(negedge clk);
    check("byp_store_cnt", 32'(f2.count), 1);
    check("byp_store_out", 32'(f2.outs), 32'h5A);
    drv();
    f2.outs_ready = 1;
    drv();
    f2.outs_ready = 0;
    @(negedge clk);
    check("byp_end_cnt", 32'(f2.count), 0);
    check("byp_sb", 32'(q2.size()), 0);
    drv();

    // Flush with three entries stored.
    for (int i = 1; i <= 3; i++) begin
      f0.ins = 8'(i);
      f0.ins_valid = 1;
      drv();
    end
    f0.ins = 8'hEE;
    f0.flush = 1;
    @(negedge clk);
    check("flush_cnt_pre", 32'(f0.count), 3);
    check("flush_irdy", 32'(f0.ins_ready), 0);
    check("flush_ovalid", 32'(f0.outs_valid), 0);
    drv();
    f0.flush = 0;
    f0.ins_valid = 0;
    @(negedge clk);
    check("flush_count", 32'(f0.count), 0);
    check("flush_ovalid2", 32'(f0.outs_valid), 0);
    drv();
    f0.ins = 8'h77;
    f0.ins_valid = 1;
    drv();
    f0.ins_valid = 0;
    f0.outs_ready = 1;
    drv();
    f0.outs_ready = 0;
    @(negedge clk);
    check("flush_sb", 32'(q0.size()), 0);
    drv();

    // Asynchronous reset between edges.
    f0.ins = 8'h31;
    f0.ins_valid = 1;
    drv();
    f0.ins = 8'h32;
    drv();
    f0.ins_valid = 0;
    #2;
    check("ar_cnt_pre", 32'(f0.count), 2);
    rst_n = 1'b0;
    q0.delete();
    #1;
    check("ar_count", 32'(f0.count), 0);
    check("ar_ovalid", 32'(f0.outs_valid), 0);
    check("ar_af", 32'(f0.almost_full), 0);
    #1 rst_n = 1'b1;
    drv();
    f0.ins = 8'h99;
    f0.ins_valid = 1;
    drv();
    f0.ins_valid = 0;
    @(negedge clk);
    check("ar_push_cnt", 32'(f0.count), 1);
    check("ar_push_out", 32'(f0.outs), 32'h99);
    drv();
    f0.outs_ready = 1;
    drv();
    f0.outs_ready = 0;
    @(negedge clk);
    check("ar_pop_cnt", 32'(f0.count), 0);
    check("ar_sb", 32'(q0.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
